// File: rtl/bullet_pool_scheduler.sv
// Fixed pool of player bullet slots: allocates on fire, advances once per frame,
// and retires slots on collision or when they leave the visible screen area.
module bullet_pool_scheduler #(
   parameter int unsigned NUM_SLOTS       = 6,
   parameter int unsigned COOLDOWN_FRAMES = 8,
   parameter int unsigned BULLET_SPEED    = 4,
   parameter int unsigned SCREEN_W        = 640,
   parameter int unsigned BULLET_SIZE     = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      VS,
   input  logic                      fire_req,
   input  logic                      direction,
   input  logic [9:0]                PlayerX,
   input  logic [9:0]                PlayerY,
   input  logic [9:0]                PlayerWidth,
   input  logic [9:0]                PlayerHeight,
   input  logic [NUM_SLOTS-1:0]      collision_hit,
   output logic [NUM_SLOTS-1:0]      slot_active,
   output logic [NUM_SLOTS-1:0]      slot_dir,
   output logic [10*NUM_SLOTS-1:0]   bullet_x,
   output logic [10*NUM_SLOTS-1:0]   bullet_y,
   output logic                      fire_ack,
   output logic                      pool_full
);

   localparam int unsigned CW          = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [10:0] RIGHT_LIMIT = 11'(SCREEN_W - BULLET_SIZE);

   typedef enum logic {SLOT_FREE, SLOT_ACTIVE} slot_state_e;
   typedef enum logic {READY, COOLDOWN}        pool_state_e;

   slot_state_e          slot_q [NUM_SLOTS];
   slot_state_e          slot_d [NUM_SLOTS];
   logic [9:0]           x_q [NUM_SLOTS];
   logic [9:0]           x_d [NUM_SLOTS];
   logic [9:0]           y_q [NUM_SLOTS];
   logic [9:0]           y_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] dir_q, dir_d;
   logic [CW-1:0]        cool_q, cool_d;
   pool_state_e          pool_q, pool_d;
   logic                 vs_q, vs_d;
   logic                 fire_ack_q, fire_ack_d;
   logic                 pool_full_q, pool_full_d;

   logic                 tick, ready, accept, found;
   logic [NUM_SLOTS-1:0] alloc_oh, active_nx;
   logic [9:0]           spawn_x, spawn_y;

   always_comb begin
      vs_d     = VS;
      tick     = VS & ~vs_q;
      found    = 1'b0;
      alloc_oh = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_q[i] == SLOT_FREE && !found) begin
            alloc_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
      // A count of 1 expires on this very tick, keeping accepted shots COOLDOWN_FRAMES ticks apart.
      ready  = (pool_q == READY) || (cool_q == CW'(1));
      accept = tick & fire_req & ready & found;

      spawn_x = direction ? PlayerX + PlayerWidth
                          : ((PlayerX < 10'(BULLET_SIZE)) ? '0 : PlayerX - 10'(BULLET_SIZE));
      spawn_y = PlayerY + (PlayerHeight >> 1);

      slot_d = slot_q;
      x_d    = x_q;
      y_d    = y_q;
      dir_d  = dir_q;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_q[i] == SLOT_ACTIVE) begin
            if (collision_hit[i]) begin
               slot_d[i] = SLOT_FREE;
            end else if (tick) begin
               if (dir_q[i] ? (({1'b0, x_q[i]} + 11'(BULLET_SPEED)) > RIGHT_LIMIT)
                            : (x_q[i] < 10'(BULLET_SPEED))) begin
                  slot_d[i] = SLOT_FREE;
               end else begin
                  x_d[i] = dir_q[i] ? x_q[i] + 10'(BULLET_SPEED) : x_q[i] - 10'(BULLET_SPEED);
               end
            end
         end else if (accept && alloc_oh[i]) begin
            slot_d[i] = SLOT_ACTIVE;
            x_d[i]    = spawn_x;
            y_d[i]    = spawn_y;
            dir_d[i]  = direction;
         end
      end

      cool_d = cool_q;
      if (tick) begin
         if (accept) begin
            cool_d = CW'(COOLDOWN_FRAMES);
         end else if (cool_q != '0) begin
            cool_d = cool_q - CW'(1);
         end
      end
      pool_d = (cool_d == '0) ? READY : COOLDOWN;

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         active_nx[i] = (slot_d[i] == SLOT_ACTIVE);
      end
      fire_ack_d  = accept;
      pool_full_d = &active_nx;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q        <= 1'b1;
         pool_q      <= READY;
         cool_q      <= '0;
         fire_ack_q  <= 1'b0;
         pool_full_q <= 1'b0;
         dir_q       <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= SLOT_FREE;
            x_q[i]    <= '0;
            y_q[i]    <= '0;
         end
      end else begin
         vs_q        <= vs_d;
         pool_q      <= pool_d;
         cool_q      <= cool_d;
         fire_ack_q  <= fire_ack_d;
         pool_full_q <= pool_full_d;
         dir_q       <= dir_d;
         slot_q      <= slot_d;
         x_q         <= x_d;
         y_q         <= y_d;
      end
   end

   always_comb begin
      slot_active = '0;
      bullet_x    = '0;
      bullet_y    = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         slot_active[i]      = (slot_q[i] == SLOT_ACTIVE);
         bullet_x[10*i +: 10] = x_q[i];
         bullet_y[10*i +: 10] = y_q[i];
      end
   end

   assign slot_dir  = dir_q;
   assign fire_ack  = fire_ack_q;
   assign pool_full = pool_full_q;

endmodule

// File: tb/tb_bullet_pool_scheduler.sv
// Self-checking bench for bullet_pool_scheduler: directed scenarios plus random
// stimulus, all compared against a frame-level behavioural model.
module tb_bullet_pool_scheduler;

   localparam int NS  = 6;
   localparam int CD  = 8;
   localparam int SPD = 4;
   localparam int SW  = 640;
   localparam int BS  = 4;
   localparam int FP  = 8;

   logic              Clk = 1'b0;
   logic              Reset, VS, fire_req, direction;
   logic [9:0]        PlayerX, PlayerY, PlayerWidth, PlayerHeight;
   logic [NS-1:0]     collision_hit;
   logic [NS-1:0]     slot_active, slot_dir;
   logic [10*NS-1:0]  bullet_x, bullet_y;
   logic              fire_ack, pool_full;

   bullet_pool_scheduler #(
      .NUM_SLOTS(NS), .COOLDOWN_FRAMES(CD), .BULLET_SPEED(SPD),
      .SCREEN_W(SW), .BULLET_SIZE(BS)
   ) dut (
      .Clk(Clk), .Reset(Reset), .VS(VS), .fire_req(fire_req), .direction(direction),
      .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerWidth(PlayerWidth),
      .PlayerHeight(PlayerHeight), .collision_hit(collision_hit),
      .slot_active(slot_active), .slot_dir(slot_dir), .bullet_x(bullet_x),
      .bullet_y(bullet_y), .fire_ack(fire_ack), .pool_full(pool_full)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ack    = 0;
   int cyc      = 0;

   // Reference model state (visible outputs after the most recent edge)
   bit m_act [NS];
   bit m_dir [NS];
   int m_x   [NS];
   int m_y   [NS];
   bit m_ack;
   bit m_prev_vs;
   int m_frame;
   int m_last_accept;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit tick;
      bit pre_act [NS];
      int slot;
      if (Reset) begin
         for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
         end
         m_ack = 0; m_prev_vs = 1; m_frame = 0; m_last_accept = -1000;
         return;
      end
      tick    = VS && !m_prev_vs;
      pre_act = m_act;
      m_ack   = 0;
      for (int i = 0; i < NS; i++) begin
         if (pre_act[i]) begin
            if (collision_hit[i]) m_act[i] = 0;
            else if (tick) begin
               if (m_dir[i]) begin
                  if (m_x[i] + SPD > SW - BS) m_act[i] = 0;
                  else m_x[i] = m_x[i] + SPD;
               end else begin
                  if (m_x[i] < SPD) m_act[i] = 0;
                  else m_x[i] = m_x[i] - SPD;
               end
            end
         end
      end
      if (tick) begin
         m_frame++;
         slot = -1;
         for (int i = NS - 1; i >= 0; i--) if (!pre_act[i]) slot = i;
         if (fire_req && (m_frame - m_last_accept >= CD) && slot >= 0) begin
            m_act[slot] = 1;
            m_dir[slot] = direction;
            if (direction) m_x[slot] = (int'(PlayerX) + int'(PlayerWidth)) % 1024;
            else m_x[slot] = (PlayerX < BS) ? 0 : int'(PlayerX) - BS;
            m_y[slot] = (int'(PlayerY) + int'(PlayerHeight) / 2) % 1024;
            m_last_accept = m_frame;
            m_ack = 1;
         end
      end
      m_prev_vs = VS;
   endtask

   task automatic compare_all();
      logic [NS-1:0]    ea, ed;
      logic [10*NS-1:0] ex, ey;
      for (int i = 0; i < NS; i++) begin
         ea[i] = m_act[i];
         ed[i] = m_dir[i];
         ex[10*i +: 10] = 10'(m_x[i]);
         ey[10*i +: 10] = 10'(m_y[i]);
      end
      check_eq("slot_active", slot_active, ea);
      check_eq("slot_dir", slot_dir, ed);
      check_eq("bullet_x", bullet_x, ex);
      check_eq("bullet_y", bullet_y, ey);
      check_eq("fire_ack", fire_ack, m_ack);
      check_eq("pool_full", pool_full, &ea);
   endtask

   // One clock: VS from the frame phase, model advanced with the applied inputs
   task automatic cycle();
      VS = ((cyc % FP) < 2);
      model_step();
      @(posedge Clk);
      #1 collision_hit = '0;
      @(negedge Clk);
      compare_all();
      if (fire_ack === 1'b1) n_ack++;
      cyc++;
   endtask

   task automatic align();
      while (cyc % FP != 0) cycle();
   endtask

   task automatic frames(input int n);
      repeat (n * FP) cycle();
   endtask

   task automatic do_reset();
      Reset = 1'b1; fire_req = 1'b0;
      cycle(); cycle();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; VS = 1'b0; fire_req = 1'b0; direction = 1'b1;
      PlayerX = '0; PlayerY = '0; PlayerWidth = '0; PlayerHeight = '0;
      collision_hit = '0;
      repeat (3) cycle();
      check_eq("reset_active", slot_active, 0);
      check_eq("reset_x", bullet_x, 0);
      Reset = 1'b0;

      // Idle frames
      frames(30);
      check_eq("idle_no_ack", n_ack, 0);
      check_eq("idle_active", slot_active, 0);

      // Right-facing spawn and first move
      align();
      PlayerX = 10'd100; PlayerWidth = 10'd20; PlayerY = 10'd200; PlayerHeight = 10'd40;
      direction = 1'b1; fire_req = 1'b1;
      cycle();
      check_eq("spawn_ack", fire_ack, 1);
      check_eq("spawn_x", bullet_x[9:0], 120);
      check_eq("spawn_y", bullet_y[9:0], 220);
      fire_req = 1'b0;
      cycle();
      check_eq("ack_one_cycle", fire_ack, 0);
      repeat (FP - 1) cycle();
      check_eq("move_x", bullet_x[9:0], 124);

      // Left spawn clamped to 0, retires on the next tick
      do_reset(); align();
      direction = 1'b0; PlayerX = 10'd2; fire_req = 1'b1;
      cycle();
      check_eq("left_spawn_x", bullet_x[9:0], 0);
      check_eq("left_active", slot_active[0], 1);
      fire_req = 1'b0;
      repeat (FP) cycle();
      check_eq("left_retired", slot_active[0], 0);
      check_eq("left_x_held", bullet_x[9:0], 0);

      // Right edge: 633 + 4 > 636 retires on the next tick
      do_reset(); align();
      direction = 1'b1; PlayerX = 10'd613; PlayerWidth = 10'd20; fire_req = 1'b1;
      cycle();
      check_eq("right_spawn_x", bullet_x[9:0], 633);
      fire_req = 1'b0;
      repeat (FP) cycle();
      check_eq("right_retired", slot_active[0], 0);
      check_eq("right_x_held", bullet_x[9:0], 633);

      // Collision retire and slot reuse rules
      do_reset(); align();
      PlayerX = 10'd100; PlayerWidth = 10'd20; direction = 1'b1; fire_req = 1'b1;
      frames(17);
      check_eq("three_live", slot_active, 6'b000111);
      fire_req = 1'b0;
      frames(8);
      repeat (4) cycle();
      collision_hit = 6'b000100;
      cycle();
      check_eq("hit_frees_slot2", slot_active, 6'b000011);
      fire_req = 1'b1;
      align();
      cycle();
      check_eq("reuse_ack", fire_ack, 1);
      check_eq("reuse_slot2", slot_active, 6'b000111);
      fire_req = 1'b0;
      align();
      frames(7);
      fire_req = 1'b1; collision_hit = 6'b000001;
      cycle();
      check_eq("tick_free_not_reused", slot_active, 6'b001110);
      fire_req = 1'b0;

      // Held fire: cooldown spacing and pool exhaustion
      do_reset(); align();
      n_ack = 0;
      PlayerX = 10'd100; PlayerWidth = 10'd20; direction = 1'b1; fire_req = 1'b1;
      frames(40);
      check_eq("held_40_acks", n_ack, 5);
      check_eq("not_full_yet", pool_full, 0);
      frames(16);
      check_eq("held_56_acks", n_ack, 6);
      check_eq("pool_full", pool_full, 1);
      check_eq("all_active", slot_active, 6'b111111);

      // Reset mid-flight with 4 live slots and cooldown 5
      do_reset(); align();
      fire_req = 1'b1;
      frames(28);
      repeat (3) cycle();
      check_eq("four_live", slot_active, 6'b001111);
      Reset = 1'b1;
      cycle();
      check_eq("midflight_reset", slot_active, 0);
      Reset = 1'b0;
      align();
      cycle();
      check_eq("post_reset_ack", fire_ack, 1);
      check_eq("post_reset_slot0", slot_active, 6'b000001);

      // Randomised traffic
      do_reset();
      repeat (1200 * FP) begin
         fire_req     = ($urandom_range(0, 3) != 0);
         direction    = 1'($urandom_range(0, 1));
         PlayerX      = 10'($urandom_range(0, 700));
         PlayerWidth  = 10'($urandom_range(0, 63));
         PlayerY      = 10'($urandom_range(0, 479));
         PlayerHeight = 10'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0) collision_hit = NS'(1) << $urandom_range(0, NS - 1);
         Reset        = ($urandom_range(0, 999) == 0);
         cycle();
      end
      Reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
